// File: rtl/pipelined_chunk_adder_pkg.sv
// Shared definitions for the chunked adder: FSM state encodings and a
// counter-width helper.
package pipelined_chunk_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // ceil(log2(n)), never less than 1 so a single-chunk counter still exists
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            r = ((32'sd1 <<< i) < n) ? (i + 1) : r;
        end
        return r;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
// Also exposes the carry into the top bit so the caller can form overflow.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ctop
);

    logic [CHUNK:0] w_carry;

    // ripple chain of full-adder cells, LSB first
    always_comb begin
        w_carry    = '0;
        o_sum      = '0;
        w_carry[0] = i_cin;
        for (int i = 0; i < CHUNK; i++) begin
            o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
            w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout = w_carry[CHUNK];
    assign o_ctop = w_carry[CHUNK-1];

endmodule

// File: rtl/pipelined_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that sums CHUNK bits per clock,
// chaining chunks through a registered carry, with valid/ready on both sides.
module pipelined_chunk_adder
    import pipelined_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c,
    output logic             out_ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = clog2_min1(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] w_s_next;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_c;
    logic             r_ovf;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic             w_ctop;
    logic             w_last;

    assign w_last = (r_cnt == LAST_IDX);

    // select chunk r_cnt of the frozen operands
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int j = 0; j < N; j++) begin
            w_a_chunk = w_a_chunk | ((r_cnt == CW'(j)) ? r_a[j*CHUNK +: CHUNK] : '0);
            w_b_chunk = w_b_chunk | ((r_cnt == CW'(j)) ? r_b[j*CHUNK +: CHUNK] : '0);
        end
    end

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk_adder (
        .i_a   (w_a_chunk),
        .i_b   (w_b_chunk),
        .i_cin (r_carry),
        .o_sum (w_sum),
        .o_cout(w_cout),
        .o_ctop(w_ctop)
    );

    // drop the chunk result into its slot of the sum register
    always_comb begin
        w_s_next = r_s;
        for (int j = 0; j < N; j++) begin
            w_s_next[j*CHUNK +: CHUNK] = (r_cnt == CW'(j)) ? w_sum : r_s[j*CHUNK +: CHUNK];
        end
    end

    // next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: w_state_next = in_valid  ? ST_RUN  : ST_IDLE;
            ST_RUN:  w_state_next = w_last    ? ST_DONE : ST_RUN;
            ST_DONE: w_state_next = out_ready ? ST_IDLE : ST_DONE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // operand capture and per-chunk accumulation; subtract is A + ~B + 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_c     <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= sub ? ~in_b : in_b;
                        r_carry <= sub ? 1'b1 : in_c;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_s     <= w_s_next;
                    r_carry <= w_cout;
                    r_cnt   <= w_last ? '0 : (r_cnt + CW'(1'b1));
                    if (w_last) begin
                        r_c   <= w_cout;
                        r_ovf <= w_ctop ^ w_cout;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_s     = r_s;
    assign out_c     = r_c;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Directed and randomised checks of pipelined_chunk_adder at WIDTH=32 with
// CHUNK = 8, 32, 1 and 4 instantiated side by side.
module tb_pipelined_chunk_adder;

    localparam int NDUT  = 4;
    localparam int LIMIT = 200;
    localparam int LAT [NDUT] = '{4, 1, 32, 8};

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sb;
        logic [31:0] s;
        logic        c;
        logic        ovf;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [NDUT];
    logic        in_ready  [NDUT];
    logic [31:0] in_a      [NDUT];
    logic [31:0] in_b      [NDUT];
    logic        in_c      [NDUT];
    logic        sub       [NDUT];
    logic        out_valid [NDUT];
    logic        out_ready [NDUT];
    logic [31:0] out_s     [NDUT];
    logic        out_c     [NDUT];
    logic        out_ovf   [NDUT];

    int n_chk = 0;
    int n_err = 0;
    vec_t vecs [9];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        pipelined_chunk_adder #(
            .WIDTH(32),
            .CHUNK((g == 0) ? 8 : (g == 1) ? 32 : (g == 2) ? 1 : 4)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_a     (in_a[g]),
            .in_b     (in_b[g]),
            .in_c     (in_c[g]),
            .sub      (sub[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_s    (out_s[g]),
            .out_c    (out_c[g]),
            .out_ovf  (out_ovf[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: actual=%0h required=%0h", nm, d, act, exp);
        end
    endtask

    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic sb);
        logic [31:0] bb;
        logic [32:0] t;
        logic        ov;
        bb = sb ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + {32'd0, (sb ? 1'b1 : ci)};
        ov = (a[31] == bb[31]) && (t[31] != a[31]);
        return {ov, t[32], t[31:0]};
    endfunction

    // accept at a posedge, then count edges until out_valid
    task automatic start_and_wait(input int d, input logic [31:0] a, input logic [31:0] b,
                                  input logic ci, input logic sb, output int lat);
        @(negedge clk);
        in_valid[d] = 1'b1; in_a[d] = a; in_b[d] = b; in_c[d] = ci; sub[d] = sb;
        @(posedge clk); #1;
        in_valid[d] = 1'b0; in_a[d] = ~a; in_b[d] = ~b; in_c[d] = ~ci; sub[d] = ~sb;
        lat = 0;
        while (out_valid[d] !== 1'b1 && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake(input int d);
        @(negedge clk);
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
    endtask

    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sb,
                          input logic [31:0] es, input logic ec, input logic eo);
        int lat;
        start_and_wait(d, a, b, ci, sb, lat);
        chk(d, "latency", lat, LAT[d]);
        chk(d, "out_s", out_s[d], es);
        chk(d, "out_c", {31'd0, out_c[d]}, {31'd0, ec});
        chk(d, "out_ovf", {31'd0, out_ovf[d]}, {31'd0, eo});
        handshake(d);
    endtask

    initial begin
        int lat;
        logic [31:0] ra, rb;
        logic rci, rsb;
        logic [33:0] m;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[6] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[8] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

        rst_n = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            in_valid[d] = 1'b0; in_a[d] = 32'd0; in_b[d] = 32'd0;
            in_c[d] = 1'b0; sub[d] = 1'b0; out_ready[d] = 1'b0;
        end
        #12;
        for (int d = 0; d < NDUT; d++) begin
            chk(d, "rst_in_ready", {31'd0, in_ready[d]}, 32'd1);
            chk(d, "rst_out_valid", {31'd0, out_valid[d]}, 32'd0);
        end
        chk(0, "rst_out_s", out_s[0], 32'd0);
        chk(0, "rst_out_c", {31'd0, out_c[0]}, 32'd0);
        chk(0, "rst_out_ovf", {31'd0, out_ovf[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed table on every chunk size
        for (int d = 0; d < NDUT; d++) begin
            for (int v = 0; v < 9; v++) begin
                run_op(d, vecs[v].a, vecs[v].b, vecs[v].ci, vecs[v].sb,
                       vecs[v].s, vecs[v].c, vecs[v].ovf);
            end
        end

        // backpressure: outputs held, second request ignored
        start_and_wait(0, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, lat);
        chk(0, "bp_latency", lat, 32'd4);
        for (int k = 0; k < 5; k++) begin
            chk(0, "bp_out_valid", {31'd0, out_valid[0]}, 32'd1);
            chk(0, "bp_in_ready", {31'd0, in_ready[0]}, 32'd0);
            chk(0, "bp_out_s", out_s[0], 32'h3333_3333);
            chk(0, "bp_out_c", {31'd0, out_c[0]}, 32'd0);
            if (k == 1) begin
                in_valid[0] = 1'b1; in_a[0] = 32'hAAAA_AAAA; in_b[0] = 32'h5555_5555;
            end else begin
                in_valid[0] = 1'b0;
            end
            @(posedge clk); #1;
        end
        handshake(0);
        chk(0, "bp_in_ready_after", {31'd0, in_ready[0]}, 32'd1);
        chk(0, "bp_out_valid_after", {31'd0, out_valid[0]}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk(0, "bp_no_accept_valid", {31'd0, out_valid[0]}, 32'd0);
        chk(0, "bp_no_accept_ready", {31'd0, in_ready[0]}, 32'd1);

        // asynchronous reset after chunk 1 of a run
        @(negedge clk);
        in_valid[0] = 1'b1; in_a[0] = 32'h0101_0101; in_b[0] = 32'h0202_0202;
        in_c[0] = 1'b0; sub[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk(0, "ar_out_valid", {31'd0, out_valid[0]}, 32'd0);
        chk(0, "ar_in_ready", {31'd0, in_ready[0]}, 32'd1);
        chk(0, "ar_out_s", out_s[0], 32'd0);
        chk(0, "ar_out_c", {31'd0, out_c[0]}, 32'd0);
        chk(0, "ar_out_ovf", {31'd0, out_ovf[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

        // random sweep against the reference model, spread over all chunk sizes
        for (int i = 0; i < 1000; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rci = 1'($urandom_range(0, 1));
            rsb = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) rb = 32'h7FFF_FFFF;
            m = model(ra, rb, rci, rsb);
            run_op(i % NDUT, ra, rb, rci, rsb, m[31:0], m[32], m[33]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
